rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 104 ++++++++++
 tb/tb_rr_arb_mux.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready arbiter-mux with a single registered output stage.
// MODE 0 = round-robin from a rotating pointer, MODE 1 = fixed priority (lowest index wins).
module rr_arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 16,
    parameter int unsigned MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic [NCH-1:0]         in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(NCH)-1:0] out_sel,
    input  logic                   out_ready
);

    localparam int unsigned SELW = $clog2(NCH);
    localparam int unsigned PW   = 1 << SELW;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic [PW-1:0]    valid_pad;
    logic [WIDTH-1:0] ch_data [PW];
    logic [SELW-1:0]  grant;
    logic             found;
    logic             any_valid;
    logic             accept;
    logic             xfer;
    int unsigned      idx;

    // Pad to a power of two so SELW-bit indices never select a missing channel.
    assign valid_pad = PW'(in_valid);

    for (genvar i = 0; i < PW; i++) begin : g_ch
        if (i < NCH) begin : g_real
            assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_data[i] = '0;
        end
    end

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = k;
            if (MODE == 0) begin
                idx = idx + 32'(ptr_q);
                if (idx >= NCH) idx = idx - NCH;
            end
            if (!found && valid_pad[idx[SELW-1:0]]) begin
                found = 1'b1;
                grant = idx[SELW-1:0];
            end
        end
    end

    assign any_valid = |in_valid;
    assign accept    = !out_valid_q || out_ready;
    assign xfer      = accept && any_valid;
    assign in_ready  = (rst_n && xfer) ? (NCH'(1) << grant) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = any_valid;
            if (any_valid) begin
                out_data_d = ch_data[grant];
                out_sel_d  = grant;
            end
        end
        if (MODE == 0 && xfer) begin
            ptr_d = (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: round-robin instance (MODE 0) and fixed-priority instance (MODE 1).
module tb_rr_arb_mux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_valid = '0;
    logic [7:0] ch_d [4];
    logic [31:0] in_data;
    logic       out_ready = 1'b0;

    logic [3:0] in_ready0, in_ready1;
    logic       out_valid0, out_valid1;
    logic [7:0] out_data0, out_data1;
    logic [1:0] out_sel0, out_sel1;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q [$];
    logic [9:0] sb_exp;
    bit sb_en = 1'b0;

    assign in_data = {ch_d[3], ch_d[2], ch_d[1], ch_d[0]};

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(8), .NCH(4), .MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_sel(out_sel0), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .NCH(4), .MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_sel(out_sel1), .out_ready(out_ready)
    );

    // Every output handshake of the round-robin instance consumes one expected item.
    always @(negedge clk) begin
        if (sb_en && rst_n && out_valid0 && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got sel=%0d data=%h expected no output", out_sel0, out_data0);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({out_sel0, out_data0} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_item got sel=%0d data=%h expected sel=%0d data=%h",
                             out_sel0, out_data0, sb_exp[9:8], sb_exp[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) ch_d[i] = 8'h00;
        rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        #2;
        checks++;
        if ({out_valid0, out_sel0, out_data0} !== 11'd0) begin
            errors++; $display("FAIL reset_outputs got %h expected 000", {out_valid0, out_sel0, out_data0});
        end
        checks++;
        if (in_ready0 !== 4'b0000 || in_ready1 !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready got %b/%b expected 0000/0000", in_ready0, in_ready1);
        end
        in_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        ch_d[2] = 8'h5A; in_valid = 4'b0100; out_ready = 1'b0;
        tick();
        checks++;
        if ({out_valid0, out_sel0, out_data0} !== {1'b1, 2'd2, 8'h5A}) begin
            errors++; $display("FAIL reset_preload got %h expected %h", {out_valid0, out_sel0, out_data0}, {1'b1, 2'd2, 8'h5A});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid0, out_sel0, out_data0} !== 11'd0) begin
            errors++; $display("FAIL reset_async got %h expected 000", {out_valid0, out_sel0, out_data0});
        end
        checks++;
        if (in_ready0 !== 4'b0000) begin
            errors++; $display("FAIL reset_async_in_ready got %b expected 0000", in_ready0);
        end
        tick();
        in_valid = 4'b0000; rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++; $display("FAIL reset_release got out_valid=%b expected 0", out_valid0);
        end
        exp_q.delete();
    endtask

    task automatic test_rr_fair();
        logic [1:0] e;
        for (int i = 0; i < 4; i++) ch_d[i] = 8'h10 + 8'(i);
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            e = 2'(n % 4);
            #1;
            checks++;
            if (in_ready0 !== (4'b0001 << e)) begin
                errors++; $display("FAIL rr_in_ready n=%0d got %b expected %b", n, in_ready0, 4'b0001 << e);
            end
            exp_q.push_back({e, ch_d[e]});
            tick();
            checks++;
            if ({out_valid0, out_sel0, out_data0} !== {1'b1, e, ch_d[e]}) begin
                errors++; $display("FAIL rr_output n=%0d got %h expected %h", n, {out_valid0, out_sel0, out_data0}, {1'b1, e, ch_d[e]});
            end
        end
    endtask

    task automatic test_idle_drain();
        ch_d[1] = 8'h77; in_valid = 4'b0010; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 4'b0010) begin
            errors++; $display("FAIL drain_in_ready got %b expected 0010", in_ready0);
        end
        exp_q.push_back({2'd1, 8'h77});
        tick();
        in_valid = 4'b0000;
        checks++;
        if ({out_valid0, out_sel0, out_data0} !== {1'b1, 2'd1, 8'h77}) begin
            errors++; $display("FAIL drain_first got %h expected %h", {out_valid0, out_sel0, out_data0}, {1'b1, 2'd1, 8'h77});
        end
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if ({out_valid0, out_sel0, out_data0} !== {1'b0, 2'd1, 8'h77}) begin
                errors++; $display("FAIL drain_idle n=%0d got %h expected %h", n, {out_valid0, out_sel0, out_data0}, {1'b0, 2'd1, 8'h77});
            end
        end
    endtask

    task automatic test_backpressure();
        ch_d[0] = 8'h01; ch_d[1] = 8'h02; ch_d[2] = 8'hA5; ch_d[3] = 8'h3C;
        in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 4'b0100) begin
            errors++; $display("FAIL bp_accept got %b expected 0100", in_ready0);
        end
        exp_q.push_back({2'd2, 8'hA5});
        tick();
        in_valid = 4'b1011; out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if (in_ready0 !== 4'b0000) begin
                errors++; $display("FAIL bp_in_ready n=%0d got %b expected 0000", n, in_ready0);
            end
            checks++;
            if ({out_valid0, out_sel0, out_data0} !== {1'b1, 2'd2, 8'hA5}) begin
                errors++; $display("FAIL bp_hold n=%0d got %h expected %h", n, {out_valid0, out_sel0, out_data0}, {1'b1, 2'd2, 8'hA5});
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 4'b1000) begin
            errors++; $display("FAIL bp_release got %b expected 1000", in_ready0);
        end
        exp_q.push_back({2'd3, 8'h3C});
        tick();
        checks++;
        if ({out_valid0, out_sel0, out_data0} !== {1'b1, 2'd3, 8'h3C}) begin
            errors++; $display("FAIL bp_next got %h expected %h", {out_valid0, out_sel0, out_data0}, {1'b1, 2'd3, 8'h3C});
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) ch_d[i] = 8'h20 + 8'(i);
        out_ready = 1'b1;
        in_valid = 4'b0010;
        #1;
        checks++;
        if (in_ready0 !== 4'b0010) begin
            errors++; $display("FAIL wrap_ch1 got %b expected 0010", in_ready0);
        end
        exp_q.push_back({2'd1, 8'h21});
        tick();
        in_valid = 4'b0001;
        #1;
        checks++;
        if (in_ready0 !== 4'b0001) begin
            errors++; $display("FAIL wrap_ch0 got %b expected 0001", in_ready0);
        end
        exp_q.push_back({2'd0, 8'h20});
        tick();
        in_valid = 4'b1001;
        #1;
        checks++;
        if (in_ready0 !== 4'b1000) begin
            errors++; $display("FAIL wrap_ptr1 got %b expected 1000", in_ready0);
        end
        exp_q.push_back({2'd3, 8'h23});
        tick();
        in_valid = 4'b0000;
        tick();
        checks++;
        if (out_valid0 !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL wrap_empty got out_valid=%b pending=%0d expected 0/0", out_valid0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ptr_m, g, idx;
        logic       ov_m, acc, fnd, r;
        logic [3:0] v, exp_rdy;
        ptr_m = 2'd0; ov_m = 1'b0;
        for (int n = 0; n < 150; n++) begin
            v = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) ch_d[i] = 8'($urandom);
            in_valid = v; out_ready = r;
            #1;
            acc = !ov_m || r;
            g = 2'd0; fnd = 1'b0;
            for (int k = 0; k < 4; k++) begin
                idx = ptr_m + 2'(k);
                if (!fnd && v[idx]) begin fnd = 1'b1; g = idx; end
            end
            exp_rdy = (acc && fnd) ? (4'b0001 << g) : 4'b0000;
            checks++;
            if (in_ready0 !== exp_rdy) begin
                errors++; $display("FAIL b2b_in_ready n=%0d got %b expected %b", n, in_ready0, exp_rdy);
            end
            if (acc && fnd) begin
                exp_q.push_back({g, ch_d[g]});
                ptr_m = g + 2'd1;
                ov_m = 1'b1;
            end else if (acc) begin
                ov_m = 1'b0;
            end
            tick();
            checks++;
            if (out_valid0 !== ov_m) begin
                errors++; $display("FAIL b2b_out_valid n=%0d got %b expected %b", n, out_valid0, ov_m);
            end
        end
        in_valid = 4'b0000; out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_fixed();
        sb_en = 1'b0;
        in_valid = 4'b0000; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) ch_d[i] = 8'h40 + 8'(i);
        in_valid = 4'b1110; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (in_ready1 !== 4'b0010) begin
                errors++; $display("FAIL fp_in_ready n=%0d got %b expected 0010", n, in_ready1);
            end
            tick();
            checks++;
            if ({out_valid1, out_sel1, out_data1} !== {1'b1, 2'd1, 8'h41}) begin
                errors++; $display("FAIL fp_output n=%0d got %h expected %h", n, {out_valid1, out_sel1, out_data1}, {1'b1, 2'd1, 8'h41});
            end
        end
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready1 !== 4'b0001) begin
            errors++; $display("FAIL fp_ch0_ready got %b expected 0001", in_ready1);
        end
        tick();
        checks++;
        if ({out_valid1, out_sel1, out_data1} !== {1'b1, 2'd0, 8'h40}) begin
            errors++; $display("FAIL fp_ch0_output got %h expected %h", {out_valid1, out_sel1, out_data1}, {1'b1, 2'd0, 8'h40});
        end
    endtask

    initial begin
        test_reset();
        sb_en = 1'b1;
        test_rr_fair();
        test_idle_drain();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_fixed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
